// File: rtl/reg_coef_solve.sv
// reg_coef_solve: regression coefficients from a symmetric 2x2 inverse and X'Y.
// One shared signed multiplier sequenced over four cycles, then round/saturate.
module reg_coef_solve #(
  parameter int INV_FRAC = 16,
  parameter int SY_W     = 24,
  parameter int SXY_W    = 32,
  parameter int OUT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      inv0,
  input  logic signed [19:0]      inv1,
  input  logic signed [20:0]      inv2,
  input  logic signed [SY_W-1:0]  sy,
  input  logic signed [SXY_W-1:0] sxy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] beta0,
  output logic signed [OUT_W-1:0] beta1,
  output logic                    sat
);

  typedef enum logic [2:0] {
    IDLE, M0, M1, M2, M3, RND, OUT
  } state_t;

  localparam logic signed [65:0] HALF =
    66'sd1 <<< (INV_FRAC - 1);
  localparam logic signed [65:0] MAXV =
    (66'sd1 <<< (OUT_W - 1)) - 66'sd1;
  localparam logic signed [65:0] MINV =
    -(66'sd1 <<< (OUT_W - 1));
  localparam logic [OUT_W-1:0] MAXO =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINO =
    {1'b1, {(OUT_W-1){1'b0}}};

  state_t state, state_nx;

  logic signed [31:0] inv0_q, inv1_q, inv2_q;
  logic signed [31:0] sy_q, sxy_q;
  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic signed [65:0] acc0, acc1;
  logic [OUT_W:0]     rs0, rs1;
  logic               take;

  // Round half toward +inf, then clip; MSB of result flags a clip.
  function automatic logic [OUT_W:0] rnd_sat(
    input logic signed [65:0] acc
  );
    logic signed [65:0] r;
    r = (acc + HALF) >>> INV_FRAC;
    if (r > MAXV)
      rnd_sat = {1'b1, MAXO};
    else if (r < MINV)
      rnd_sat = {1'b1, MINO};
    else
      rnd_sat = {1'b0, r[OUT_W-1:0]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign take      = in_valid & in_ready;
  assign prod      = mul_a * mul_b;
  assign rs0       = rnd_sat(acc0);
  assign rs1       = rnd_sat(acc1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Sequencing: fixed walk through the products, wait in OUT for the consumer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = M0;
      M0:      state_nx = M1;
      M1:      state_nx = M2;
      M2:      state_nx = M3;
      M3:      state_nx = RND;
      RND:     state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand select for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      M0: begin mul_a = inv0_q; mul_b = sy_q;  end
      M1: begin mul_a = inv1_q; mul_b = sxy_q; end
      M2: begin mul_a = inv1_q; mul_b = sy_q;  end
      M3: begin mul_a = inv2_q; mul_b = sxy_q; end
      default: ;
    endcase
  end

  // Operand capture, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv0_q <= '0;
      inv1_q <= '0;
      inv2_q <= '0;
      sy_q   <= '0;
      sxy_q  <= '0;
      acc0   <= '0;
      acc1   <= '0;
      beta0  <= '0;
      beta1  <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          inv0_q <= inv0;
          inv1_q <= 32'(inv1);
          inv2_q <= 32'(inv2);
          sy_q   <= 32'(sy);
          sxy_q  <= 32'(sxy);
          acc0   <= '0;
          acc1   <= '0;
        end
        M0, M1: acc0 <= acc0 + 66'(prod);
        M2, M3: acc1 <= acc1 + 66'(prod);
        RND: begin
          beta0 <= rs0[OUT_W-1:0];
          beta1 <= rs1[OUT_W-1:0];
          sat   <= rs0[OUT_W] | rs1[OUT_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_coef_solve.sv
// tb_reg_coef_solve: directed and random jobs through reg_coef_solve.
// Expected results are queued at drive time and popped on out_valid.
module tb_reg_coef_solve;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] inv0;
  logic signed [19:0] inv1;
  logic signed [20:0] inv2;
  logic signed [23:0] sy;
  logic signed [31:0] sxy;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] beta0;
  logic signed [31:0] beta1;
  logic               sat;

  typedef struct {
    logic [31:0] b0;
    logic [31:0] b1;
    logic        s;
  } res_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  reg_coef_solve dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inv0(inv0), .inv1(inv1), .inv2(inv2),
    .sy(sy), .sxy(sxy),
    .out_valid(out_valid), .out_ready(out_ready),
    .beta0(beta0), .beta1(beta1), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference: exact wide arithmetic, floor((acc+2^15)/2^16), clip.
  function automatic logic [32:0] rs(
    input logic signed [127:0] a
  );
    logic signed [127:0] r;
    r = (a + 128'sd32768) >>> 16;
    if (r > 128'sd2147483647)
      return {1'b1, 32'h7FFFFFFF};
    if (r < -128'sd2147483648)
      return {1'b1, 32'h80000000};
    return {1'b0, r[31:0]};
  endfunction

  function automatic res_t model(
    input logic signed [31:0] i0,
    input logic signed [19:0] i1,
    input logic signed [20:0] i2,
    input logic signed [23:0] y,
    input logic signed [31:0] xy
  );
    logic signed [127:0] a0, a1;
    logic [32:0] r0, r1;
    res_t o;
    a0 = 128'(i0) * 128'(y) + 128'(i1) * 128'(xy);
    a1 = 128'(i1) * 128'(y) + 128'(i2) * 128'(xy);
    r0 = rs(a0);
    r1 = rs(a1);
    o.b0 = r0[31:0];
    o.b1 = r1[31:0];
    o.s  = r0[32] | r1[32];
    return o;
  endfunction

  function automatic res_t mk(logic [31:0] b0,
                              logic [31:0] b1,
                              logic s);
    res_t o;
    o.b0 = b0; o.b1 = b1; o.s = s;
    return o;
  endfunction

  task automatic drive(logic [31:0] i0, logic [19:0] i1,
                       logic [20:0] i2, logic [23:0] y,
                       logic [31:0] xy);
    inv0 = i0; inv1 = i1; inv2 = i2; sy = y; sxy = xy;
    in_valid = 1'b1;
  endtask

  task automatic scramble();
    inv0 = $urandom; inv1 = 20'($urandom);
    inv2 = 21'($urandom); sy = 24'($urandom);
    sxy = $urandom;
  endtask

  // Hold in_valid until the accepting edge, then drop and scramble.
  task automatic accept(string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_acc_to"}, 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Wait for out_valid (from just after accept), compare, handshake.
  task automatic collect(string tag, bit lat);
    int n = 0;
    res_t e;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_out_to"}, 32'(out_valid), 32'd1);
    if (lat) chk({tag, "_lat"}, 32'(n), 32'd5);
    e = sb.pop_front();
    chk({tag, "_b0"}, beta0, e.b0);
    chk({tag, "_b1"}, beta1, e.b1);
    chk({tag, "_sat"}, 32'(sat), 32'(e.s));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
    chk({tag, "_ir1"}, 32'(in_ready), 32'd1);
  endtask

  task automatic job(string tag, logic [31:0] i0,
                     logic [19:0] i1, logic [20:0] i2,
                     logic [23:0] y, logic [31:0] xy);
    sb.push_back(model(i0, i1, i2, y, xy));
    drive(i0, i1, i2, y, xy);
    accept(tag);
    collect(tag, 1'b1);
  endtask

  task automatic djob(string tag, logic [31:0] i0,
                      logic [19:0] i1, logic [20:0] i2,
                      logic [23:0] y, logic [31:0] xy,
                      res_t e);
    sb.push_back(e);
    drive(i0, i1, i2, y, xy);
    accept(tag);
    collect(tag, 1'b1);
  endtask

  initial begin
    logic [31:0] h0, h1;
    logic        hs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    #12;
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_b0", beta0, 32'd0);
    chk("rst_b1", beta1, 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    djob("t1", 32'd65536, 20'd0, 21'd131072, 24'd10, 32'd3,
         mk(32'd10, 32'd6, 1'b0));
    djob("t2", 32'd65536, 20'hF8000, 21'd65536, 24'd4, 32'd2,
         mk(32'd3, 32'd0, 1'b0));
    djob("t3a", 32'd1, 20'd0, 21'd0, 24'd32768, 32'd0,
         mk(32'd1, 32'd0, 1'b0));
    djob("t3b", 32'd0, 20'hFFFFF, 21'd0, 24'd0, 32'd32768,
         mk(32'd0, 32'd0, 1'b0));
    djob("t4a", 32'h7FFFFFFF, 20'd0, 21'd0, 24'h7FFFFF, 32'd0,
         mk(32'h7FFFFFFF, 32'd0, 1'b1));
    djob("t4b", 32'h80000000, 20'd0, 21'd0, 24'h7FFFFF, 32'd0,
         mk(32'h80000000, 32'd0, 1'b1));

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, d;
      logic [19:0] b;
      logic [20:0] c;
      logic [23:0] y;
      a = $urandom; b = 20'($urandom); c = 21'($urandom);
      y = 24'($urandom); d = $urandom;
      if (i < 3) begin
        a = 32'($signed(a[19:0]));
        y = 24'($signed(y[11:0]));
        d = 32'($signed(d[11:0]));
      end
      job($sformatf("rnd%0d", i), a, b, c, y, d);
    end

    // T5: result pending with out_ready low and new operands offered.
    sb.push_back(mk(32'd10, 32'd6, 1'b0));
    drive(32'd65536, 20'd0, 21'd131072, 24'd10, 32'd3);
    accept("t5a");
    sb.push_back(model(32'd65536, 20'hF8000, 21'd65536,
                       24'd4, 32'd2));
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_ov", 32'(out_valid), 32'd1);
    h0 = beta0; h1 = beta1; hs = sat;
    drive(32'd65536, 20'hF8000, 21'd65536, 24'd4, 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t5_hold_b0", beta0, h0);
      chk("t5_hold_b1", beta1, h1);
      chk("t5_hold_sat", 32'(sat), 32'(hs));
      chk("t5_hold_ir", 32'(in_ready), 32'd0);
      chk("t5_hold_ov", 32'(out_valid), 32'd1);
    end
    begin
      res_t e;
      e = sb.pop_front();
      chk("t5a_b0", beta0, e.b0);
      chk("t5a_b1", beta1, e.b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t5_idle_ir", 32'(in_ready), 32'd1);
    chk("t5_idle_ov", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t5b_taken", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    scramble();
    collect("t5b", 1'b1);

    // T6: reset in M2 after a nonzero result is on the outputs.
    drive(32'd65536, 20'd0, 21'd131072, 24'd10, 32'd3);
    accept("t6");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_ov", 32'(out_valid), 32'd0);
    chk("t6_ir", 32'(in_ready), 32'd1);
    chk("t6_b0", beta0, 32'd0);
    chk("t6_b1", beta1, 32'd0);
    chk("t6_sat", 32'(sat), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    job("t6post", 32'hFFFE0000, 20'd98304, 21'h1F0000,
        24'd1000, 32'hFFFFF000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
